addsub_arbiter: RTL and testbench

- Shares one registered 4-bit add/subtract datapath between NUM_REQ requesters.
- Each requester issues an operation through a valid/ready request handshake and receives its result through a valid/ready response handshake.
- Round-robin grant; one operation in flight at a time.
- The controller drives the datapath operand registers and captures the datapath result after a fixed latency. It sits between the requester agents and the datapath instance.

---
 rtl/addsub_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/addsub_arbiter.sv | 107 ++++++++++
 tb/tb_addsub_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_ctrl_pkg
// Brief    : Shared constants, state encoding and reference arithmetic for
//            the add/subtract arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_ctrl_pkg;

  // Default datapath geometry
  localparam int DEF_DW  = 4;
  localparam int DEF_LAT = 1;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Operation encoding on req_op / dp_op
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Reference result: DW+1 bits, subtract wraps modulo 2^(DW+1)
  function automatic logic [DEF_DW:0] ref_result(input logic [DEF_DW-1:0] a,
                                                 input logic [DEF_DW-1:0] b,
                                                 input logic              op);
    if (op == OP_SUB) ref_result = {1'b0, a} - {1'b0, b};
    else              ref_result = {1'b0, a} + {1'b0, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Searches from ptr+1 with wrap
//            and returns the first active request as one-hot and as index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);

  // First active request after the pointer wins; the pointer itself is last
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any_req && req[(int'(ptr) + i) % NUM_REQ]) begin
        grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        grant_idx = IW'((int'(ptr) + i) % NUM_REQ);
        any_req   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : addsub_arbiter
// Brief    : Shares one registered add/subtract datapath between NUM_REQ
//            requesters. Round-robin grant, one operation in flight, result
//            captured LAT+1 clocks after the request handshake and held
//            until the owning requester accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_arbiter
  import addsub_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DW      = DEF_DW,
  parameter int LAT     = DEF_LAT
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DW-1:0]      req_a,
  input  logic [NUM_REQ*DW-1:0]      req_b,
  input  logic [NUM_REQ-1:0]         req_op,
  output logic [DW-1:0]              dp_a,
  output logic [DW-1:0]              dp_b,
  output logic                       dp_op,
  input  logic [DW:0]                dp_y,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DW:0]                rsp_data,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LAT + 1);

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Ready only in IDLE and never while reset is asserted
  assign req_ready = (arst && (state == IDLE)) ? arb_grant : '0;
  assign busy      = (state != IDLE);

  // Control FSM: grant, count down datapath latency, hold response
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      ptr       <= IW'(NUM_REQ - 1);
      cnt       <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_op     <= 1'b0;
      rsp_data  <= '0;
      rsp_valid <= '0;
      grant_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            dp_a     <= req_a[arb_idx*DW +: DW];
            dp_b     <= req_b[arb_idx*DW +: DW];
            dp_op    <= req_op[arb_idx];
            grant_id <= arb_idx;
            ptr      <= arb_idx;
            cnt      <= CW'(LAT);
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_data  <= dp_y;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // Only the owner's ready bit completes the response
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_arbiter
// Brief    : Directed bench for addsub_arbiter: a LAT=1 instance for the main
//            scenarios and a LAT=3 instance for the latency check. The shared
//            datapath is modelled here as a LAT-deep register pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;
  import addsub_ctrl_pkg::*;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  // LAT=1 instance
  logic       arst0;
  logic [1:0] req_valid0, req_ready0, req_op0, rsp_valid0, rsp_ready0;
  logic [7:0] req_a0, req_b0;
  logic [3:0] dp_a0, dp_b0;
  logic       dp_op0, busy0, grant_id0;
  logic [4:0] dp_y0, rsp_data0;

  // LAT=3 instance
  logic       arst1;
  logic [1:0] req_valid1, req_ready1, req_op1, rsp_valid1, rsp_ready1;
  logic [7:0] req_a1, req_b1;
  logic [3:0] dp_a1, dp_b1;
  logic       dp_op1, busy1, grant_id1;
  logic [4:0] dp_y1, rsp_data1;
  logic [4:0] pipe1 [0:2];

  addsub_arbiter #(.NUM_REQ(2), .DW(4), .LAT(1)) dut0 (
    .aclk(aclk), .arst(arst0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_a(req_a0), .req_b(req_b0), .req_op(req_op0), .dp_a(dp_a0), .dp_b(dp_b0),
    .dp_op(dp_op0), .dp_y(dp_y0), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
    .rsp_ready(rsp_ready0), .busy(busy0), .grant_id(grant_id0)
  );

  addsub_arbiter #(.NUM_REQ(2), .DW(4), .LAT(3)) dut1 (
    .aclk(aclk), .arst(arst1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_op(req_op1), .dp_a(dp_a1), .dp_b(dp_b1),
    .dp_op(dp_op1), .dp_y(dp_y1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .rsp_ready(rsp_ready1), .busy(busy1), .grant_id(grant_id1)
  );

  // Datapath models: result valid LAT clocks after the operands update
  always_ff @(posedge aclk) dp_y0 <= ref_result(dp_a0, dp_b0, dp_op0);

  always_ff @(posedge aclk) begin
    pipe1[0] <= ref_result(dp_a1, dp_b1, dp_op1);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign dp_y1 = pipe1[2];

  typedef struct {
    int         r;
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [4:0] want;
  } vec_t;

  vec_t single_v [6];
  vec_t cont_v   [6];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive0(input int r, input logic [3:0] a, input logic [3:0] b, input logic op);
    req_a0[r*4 +: 4] = a;
    req_b0[r*4 +: 4] = b;
    req_op0[r]       = op;
    req_valid0[r]    = 1'b1;
  endtask

  // One uncontended operation on the LAT=1 instance with rsp_ready tied high
  task automatic do_op(input vec_t v);
    drive0(v.r, v.a, v.b, v.op);
    #1;
    check("single req_ready", req_ready0, 1 << v.r);
    tick();
    req_valid0[v.r] = 1'b0;
    check("single busy", busy0, 1);
    check("single grant_id", grant_id0, v.r);
    check("single dp_a", dp_a0, v.a);
    check("single dp_b", dp_b0, v.b);
    check("single dp_op", dp_op0, v.op);
    tick();
    check("single early rsp_valid", rsp_valid0, 0);
    tick();
    check("single rsp_valid", rsp_valid0, 1 << v.r);
    check("single rsp_data", rsp_data0, v.want);
    tick();
    check("single rsp cleared", rsp_valid0, 0);
    check("single idle", busy0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    single_v[0] = '{0, 4'd9,  4'd8,  OP_ADD, 5'h11};
    single_v[1] = '{1, 4'd3,  4'd5,  OP_SUB, 5'h1E};
    single_v[2] = '{0, 4'd15, 4'd1,  OP_ADD, 5'h10};
    single_v[3] = '{1, 4'd0,  4'd1,  OP_SUB, 5'h1F};
    single_v[4] = '{0, 4'd7,  4'd7,  OP_SUB, 5'h00};
    single_v[5] = '{1, 4'd15, 4'd15, OP_ADD, 5'h1E};
    // Contention order: requester = index % 2
    cont_v[0] = '{0, 4'd1,  4'd2,  OP_ADD, 5'h03};
    cont_v[1] = '{1, 4'd5,  4'd3,  OP_SUB, 5'h02};
    cont_v[2] = '{0, 4'd4,  4'd4,  OP_ADD, 5'h08};
    cont_v[3] = '{1, 4'd2,  4'd9,  OP_SUB, 5'h19};
    cont_v[4] = '{0, 4'd15, 4'd14, OP_ADD, 5'h1D};
    cont_v[5] = '{1, 4'd8,  4'd8,  OP_SUB, 5'h00};

    arst0 = 1'b0; arst1 = 1'b0;
    req_valid0 = '0; req_op0 = '0; req_a0 = '0; req_b0 = '0; rsp_ready0 = 2'b11;
    req_valid1 = '0; req_op1 = '0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 2'b11;
    drive0(0, cont_v[0].a, cont_v[0].b, cont_v[0].op);
    drive0(1, cont_v[1].a, cont_v[1].b, cont_v[1].op);
    #2;
    // Reset state, with both requests already pending
    check("reset req_ready", req_ready0, 0);
    check("reset busy", busy0, 0);
    check("reset rsp_valid", rsp_valid0, 0);
    check("reset grant_id", grant_id0, 0);
    check("reset dp_a", dp_a0, 0);
    check("reset rsp_data", rsp_data0, 0);
    check("reset busy lat3", busy1, 0);
    tick();
    tick();
    arst0 = 1'b1; arst1 = 1'b1;
    #1;

    // Contention: grants alternate 0,1,0,1,0,1
    for (int n = 0; n < 6; n++) begin
      w = n % 2;
      check("cont req_ready", req_ready0, 1 << w);
      tick();
      if (n + 2 < 6) drive0(w, cont_v[n+2].a, cont_v[n+2].b, cont_v[n+2].op);
      else req_valid0[w] = 1'b0;
      check("cont grant_id", grant_id0, w);
      check("cont busy req_ready", req_ready0, 0);
      tick();
      tick();
      check("cont rsp_valid", rsp_valid0, 1 << w);
      check("cont rsp_data", rsp_data0, cont_v[n].want);
      tick();
      #1;
    end

    // Uncontended table
    for (int i = 0; i < 6; i++) do_op(single_v[i]);

    // Response backpressure on requester 0; requester 1 waits meanwhile
    rsp_ready0 = 2'b10;
    drive0(0, 4'd6, 4'd3, OP_SUB);
    #1;
    check("bp req_ready", req_ready0, 2'b01);
    tick();
    req_valid0[0] = 1'b0;
    drive0(1, 4'd1, 4'd1, OP_ADD);
    tick();
    tick();
    check("bp rsp_valid", rsp_valid0, 2'b01);
    check("bp rsp_data", rsp_data0, 5'h03);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold rsp_valid", rsp_valid0, 2'b01);
      check("bp hold rsp_data", rsp_data0, 5'h03);
      check("bp hold req_ready", req_ready0, 0);
      check("bp hold busy", busy0, 1);
    end
    rsp_ready0 = 2'b11;
    tick();
    check("bp release rsp_valid", rsp_valid0, 0);
    check("bp release idle", busy0, 0);
    check("bp next req_ready", req_ready0, 2'b10);
    tick();
    req_valid0[1] = 1'b0;
    tick();
    tick();
    check("bp req1 rsp_valid", rsp_valid0, 2'b10);
    check("bp req1 rsp_data", rsp_data0, 5'h02);
    tick();

    // Reset in the middle of EXEC after granting requester 1 then 0
    drive0(0, 4'd5, 4'd5, OP_ADD);
    #1;
    tick();
    req_valid0[0] = 1'b0;
    check("rst pre busy", busy0, 1);
    check("rst pre dp_a", dp_a0, 4'd5);
    #2;
    arst0 = 1'b0;
    #1;
    check("rst async busy", busy0, 0);
    check("rst async rsp_valid", rsp_valid0, 0);
    check("rst async dp_a", dp_a0, 0);
    check("rst async dp_b", dp_b0, 0);
    check("rst async rsp_data", rsp_data0, 0);
    check("rst async grant_id", grant_id0, 0);
    check("rst async req_ready", req_ready0, 0);
    tick();
    tick();
    arst0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst after rsp_valid", rsp_valid0, 0);
      check("rst after busy", busy0, 0);
    end
    drive0(0, 4'd2, 4'd1, OP_ADD);
    drive0(1, 4'd4, 4'd4, OP_SUB);
    #1;
    check("rst first winner", req_ready0, 2'b01);
    tick();
    req_valid0[0] = 1'b0;
    check("rst grant_id", grant_id0, 0);
    tick();
    tick();
    check("rst op rsp_valid", rsp_valid0, 2'b01);
    check("rst op rsp_data", rsp_data0, 5'h03);
    tick();
    req_valid0 = '0;

    // LAT=3 instance: response four clocks after the handshake
    req_a1[3:0] = 4'd15;
    req_b1[3:0] = 4'd15;
    req_op1[0]  = OP_ADD;
    req_valid1  = 2'b01;
    #1;
    check("lat3 req_ready", req_ready1, 2'b01);
    tick();
    req_valid1 = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("lat3 early rsp_valid", rsp_valid1, 0);
    end
    tick();
    check("lat3 rsp_valid", rsp_valid1, 2'b01);
    check("lat3 rsp_data", rsp_data1, 5'h1E);
    tick();
    check("lat3 idle", busy1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
